seq_matcher_param: RTL
======================

Name: seq_matcher_param

Overview:
- Parametrised successor of the fixed 16-symbol sequence analyser.
- Compares a CE-qualified symbol stream against a pattern stored in runtime-programmable registers.
- Tracks partial-match progress correctly across overlapping prefixes: longest suffix of the stream that equals a pattern prefix.
- Drives a thermometer LED bar, a one-cycle match pulse and a saturating match counter; sits between the input-symbol source and the board LED/display logic.

Parameters:
- W, 4, symbol width in bits.
- N, 16, pattern length in symbols (2..32).
- CW, 8, match counter width.
- PAT_INIT, 64'hB4B3_A295_3F23_5C74, reset pattern (N*W bits); symbol i = PAT_INIT[i*W +: W]; symbol 0 is expected first (default sequence 4,7,C,5,3,2,F,3,5,9,2,A,3,B,4,B).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  sample enable; DAT_I is consumed only when high.
- DAT_I  in  W  input symbol.
- MODE_OVL  in  1  1 = overlapping matches allowed, 0 = history flushed after each match.
- CLR  in  1  synchronous clear of history, progress and counter.
- PAT_WE  in  1  pattern register write strobe.
- PAT_ADDR  in  clog2(N)  pattern index to write.
- PAT_DAT  in  W  pattern symbol to write.
- PROG  out  clog2(N+1)  current match progress, 0..N.
- LED  out  N  thermometer of PROG: LED[i] = (i < PROG).
- MATCH  out  1  one-cycle pulse on full match.
- MATCH_CNT  out  CW  saturating count of matches.

Behaviour:
- Reset (RST_N low, async): PAT = PAT_INIT; history empty (HCNT = 0); PROG = 0; LED = 0; MATCH = 0; MATCH_CNT = 0.
- History: shift register of the last N-1 accepted symbols plus valid count HCNT, which saturates at N-1.
- CE sample: candidate window = history + DAT_I. PROG_next = the largest k in 1..N where the last k symbols equal PAT[0..k-1], counting only valid history (k-1 <= HCNT). PROG_next = 0 if no k qualifies. The search is combinational, no extra cycles.
- Latency: PROG, LED and MATCH all update at the CLK edge that samples CE=1, and are visible the following cycle. LED is registered together with PROG, so there is no added delay.
- Full match (PROG_next = N): MATCH = 1 for exactly one cycle; MATCH_CNT += 1, saturating at all-ones with no wrap.
- MODE_OVL = 0, after a full match: HCNT is forced to 0, so the next match needs N fresh symbols. PROG holds N until the next CE, then is recomputed from the empty history.
- MODE_OVL = 1, after a full match: history is retained, so a periodic pattern can match again after fewer than N symbols.
- CE = 0: all state holds; MATCH = 0.
- PAT_WE = 1 with PAT_ADDR < N: PAT[PAT_ADDR] <= PAT_DAT. History, HCNT, PROG and LED are cleared; MATCH_CNT is kept.
- PAT_ADDR >= N: the write is ignored, including the clear.
- Priority: CLR > PAT_WE > CE. A CE sample in the same cycle as CLR or a valid PAT_WE is discarded and MATCH = 0. CLR does not alter PAT.
- MODE_OVL changes take effect on the next full match only.
- Reset asserted mid-sequence: immediate return to reset values, including the pattern reverting to PAT_INIT.

Test Plan:
- Default pattern 4,7,C,5,3,2,F,3,5,9,2,A,3,B,4,B, one symbol per CE -> PROG steps 1..16, LED steps 0x0001..0xFFFF, MATCH pulses once, MATCH_CNT = 1.
- Stream 4,7,4,7,C,... (rest of pattern) -> PROG goes 1,2,1,2,3,... (restart on the repeated 4); match detected with PROG = 16 at the last symbol.
- N=4, pattern A,B,A,B, stream A,B,A,B,A,B: with MODE_OVL=1 -> MATCH on symbols 4 and 6, MATCH_CNT = 2; with MODE_OVL=0 -> MATCH on symbol 4 only, PROG after symbol 6 = 2.
- Write PAT[0]=1 mid-sequence at PROG = 5 -> PROG = 0 and LED = 0 next cycle, MATCH_CNT unchanged. A same-cycle CE symbol is ignored. Write with PAT_ADDR = N -> no effect at all.
- CW=2, five full matches -> MATCH_CNT = 3 (saturated). CLR asserted together with CE on a completing symbol -> no MATCH, all outputs 0.
- RST_N pulsed low asynchronously between clock edges at PROG = 9 after reprogramming the pattern -> outputs 0 immediately; the default pattern matches again afterwards.

Source files
------------

// File: rtl/seq_matcher_param.sv
// seq_matcher_param: programmable-pattern sequence matcher
// longest-prefix progress, thermometer LEDs, match pulse and counter
module seq_matcher_param #(
  parameter int W = 4,
  parameter int N = 16,
  parameter int CW = 8,
  parameter logic [N*W-1:0] PAT_INIT = 64'hB4B3_A295_3F23_5C74
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CE,
  input  logic [W-1:0]           DAT_I,
  input  logic                   MODE_OVL,
  input  logic                   CLR,
  input  logic                   PAT_WE,
  input  logic [$clog2(N)-1:0]   PAT_ADDR,
  input  logic [W-1:0]           PAT_DAT,
  output logic [$clog2(N+1)-1:0] PROG,
  output logic [N-1:0]           LED,
  output logic                   MATCH,
  output logic [CW-1:0]          MATCH_CNT
);

  localparam int PW = $clog2(N + 1);
  localparam int HW = $clog2(N);

  logic [W-1:0]  r_pat [N];
  logic [W-1:0]  r_hist [N-1];
  logic [HW-1:0] r_hcnt;
  logic [PW-1:0] r_prog;
  logic [N-1:0]  r_led;
  logic          r_match;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_win [N];
  logic [PW-1:0] w_prog_nx;
  logic [N-1:0]  w_led_nx;
  logic          w_full;
  logic          w_addr_ok;

  // candidate window: oldest history first, incoming symbol last
  always_comb begin
    w_win[N-1] = DAT_I;
    for (int m = 1; m < N; m++) begin
      w_win[N-1-m] = r_hist[m-1];
    end
  end

  // longest window suffix equal to a pattern prefix over valid history
  always_comb begin
    logic v_ok;
    w_prog_nx = '0;
    v_ok = 1'b0;
    for (int k = 1; k <= N; k++) begin
      v_ok = ((k - 1) <= int'(r_hcnt));
      for (int i = 0; i < k; i++) begin
        if (r_pat[i] != w_win[N-k+i]) begin
          v_ok = 1'b0;
        end
      end
      if (v_ok) begin
        w_prog_nx = PW'(k);
      end
    end
  end

  // thermometer of next progress, full-match and address-range flags
  always_comb begin
    w_led_nx = '0;
    for (int i = 0; i < N; i++) begin
      w_led_nx[i] = (i < int'(w_prog_nx));
    end
    w_full    = (w_prog_nx == PW'(N));
    w_addr_ok = (int'(PAT_ADDR) < N);
  end

  // state update: clear beats pattern write beats symbol sample
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) begin
        r_pat[i] <= PAT_INIT[i*W +: W];
      end
      for (int m = 0; m < N-1; m++) begin
        r_hist[m] <= '0;
      end
      r_hcnt  <= '0;
      r_prog  <= '0;
      r_led   <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_match <= 1'b0;
      if (CLR) begin
        r_hcnt <= '0;
        r_prog <= '0;
        r_led  <= '0;
        r_cnt  <= '0;
      end else if (PAT_WE && w_addr_ok) begin
        r_pat[PAT_ADDR] <= PAT_DAT;
        r_hcnt <= '0;
        r_prog <= '0;
        r_led  <= '0;
      end else if (CE) begin
        r_hist[0] <= DAT_I;
        for (int m = 1; m < N-1; m++) begin
          r_hist[m] <= r_hist[m-1];
        end
        if (w_full && !MODE_OVL) begin
          r_hcnt <= '0;
        end else if (r_hcnt != HW'(N-1)) begin
          r_hcnt <= r_hcnt + HW'(1);
        end
        r_prog  <= w_prog_nx;
        r_led   <= w_led_nx;
        r_match <= w_full;
        if (w_full && (r_cnt != '1)) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign PROG      = r_prog;
  assign LED       = r_led;
  assign MATCH     = r_match;
  assign MATCH_CNT = r_cnt;

endmodule
